// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory request/response channel and
// the single-entry decode slot handed to the decode stage.
interface pc_fetch_ctrl_if;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_ready;

   // Fetch controller side.
   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output if_valid, if_instr, if_pc,
      input  if_ready
   );

   // Memory / decode side.
   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  if_valid, if_instr, if_pc,
      output if_ready
   );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// RV32I fetch controller: owns the fetch PC, issues one outstanding
// instruction-memory request at a time, and parks the returned word in a
// single-entry decode slot. Redirects from execute flush the slot and steer
// fetch; a misaligned redirect target halts fetch until reset.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc,
   input  logic [31:0] pc_plus4,
   input  logic [31:0] add_extend,
   input  logic [31:0] jalr_target,
   input  logic        redirect_valid,
   input  logic [1:0]  redirect_sel,
   input  logic        stall,
   output logic        misalign_exc,
   pc_fetch_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      DROP = 3'd3,
      HALT = 3'd4
   } state_t;

   state_t      state_reg;
   logic [31:0] pc_reg;
   logic [31:0] req_pc_reg;
   logic        req_valid_reg;
   logic        if_valid_reg;
   logic [31:0] if_instr_reg;
   logic [31:0] if_pc_reg;
   logic        misalign_reg;

   logic        redirect_hit;
   logic [31:0] redirect_target;
   logic        target_misaligned;
   logic        slot_free;

   // Redirect decode: sel 00/11 are treated as no redirect at all.
   always_comb begin
      redirect_hit      = redirect_valid && ((redirect_sel == 2'b01) || (redirect_sel == 2'b10));
      redirect_target   = (redirect_sel == 2'b01) ? add_extend : (jalr_target & 32'hFFFF_FFFE);
      target_misaligned = redirect_target[1];
      slot_free         = !if_valid_reg || bus.if_ready;
   end

   assign pc                 = pc_reg;
   assign misalign_exc       = misalign_reg;
   assign bus.imem_req_valid = req_valid_reg;
   assign bus.imem_req_addr  = pc_reg;
   assign bus.if_valid       = if_valid_reg;
   assign bus.if_instr       = if_instr_reg;
   assign bus.if_pc          = if_pc_reg;

   // Fetch FSM with registered request and decode-slot outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         pc_reg        <= RESET_PC;
         req_pc_reg    <= 32'h0;
         req_valid_reg <= 1'b0;
         if_valid_reg  <= 1'b0;
         if_instr_reg  <= NOP_INSTR;
         if_pc_reg     <= 32'h0;
         misalign_reg  <= 1'b0;
      end else begin
         // Decode consumes the slot; a response loading this cycle overrides.
         if (if_valid_reg && bus.if_ready) begin
            if_valid_reg <= 1'b0;
            if_instr_reg <= NOP_INSTR;
         end

         case (state_reg)
            HALT: ;
            default: begin
               if (redirect_hit && target_misaligned) begin
                  // Bad target: keep pc, flush, and stop fetching for good.
                  misalign_reg  <= 1'b1;
                  if_valid_reg  <= 1'b0;
                  if_instr_reg  <= NOP_INSTR;
                  req_valid_reg <= 1'b0;
                  state_reg     <= HALT;
               end else if (redirect_hit) begin
                  pc_reg <= redirect_target;
                  if (state_reg != DROP) begin
                     if_valid_reg <= 1'b0;
                     if_instr_reg <= NOP_INSTR;
                  end
                  case (state_reg)
                     REQ: begin
                        // An accepted request is now wrong-path and its
                        // response must be swallowed in DROP.
                        req_valid_reg <= 1'b0;
                        state_reg     <= bus.imem_req_ready ? DROP : IDLE;
                     end
                     WAIT:    state_reg <= bus.imem_rsp_valid ? IDLE : DROP;
                     DROP:    if (bus.imem_rsp_valid) state_reg <= IDLE;
                     default: ;
                  endcase
               end else begin
                  case (state_reg)
                     IDLE: begin
                        if (!stall && slot_free) begin
                           req_valid_reg <= 1'b1;
                           state_reg     <= REQ;
                        end
                     end
                     REQ: begin
                        // Held until accepted regardless of stall.
                        if (bus.imem_req_ready) begin
                           req_pc_reg    <= pc_reg;
                           pc_reg        <= pc_plus4;
                           req_valid_reg <= 1'b0;
                           state_reg     <= WAIT;
                        end
                     end
                     WAIT: begin
                        if (bus.imem_rsp_valid) begin
                           if_instr_reg <= bus.imem_rsp_data;
                           if_pc_reg    <= req_pc_reg;
                           if_valid_reg <= 1'b1;
                           state_reg    <= IDLE;
                        end
                     end
                     DROP:    if (bus.imem_rsp_valid) state_reg <= IDLE;
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a variable-latency instruction memory
// model and a decode-side monitor feed per-scenario tasks.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] add_extend;
   logic [31:0] jalr_target;
   logic        redirect_valid;
   logic [1:0]  redirect_sel;
   logic        stall;
   logic        misalign_exc;

   pc_fetch_ctrl_if bus_if ();

   pc_fetch_ctrl #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc             (pc),
      .pc_plus4       (pc_plus4),
      .add_extend     (add_extend),
      .jalr_target    (jalr_target),
      .redirect_valid (redirect_valid),
      .redirect_sel   (redirect_sel),
      .stall          (stall),
      .misalign_exc   (misalign_exc),
      .bus            (bus_if)
   );

   always #5 clk = ~clk;

   // External pc_add4 adder.
   assign pc_plus4 = pc + 32'd4;

   int errors = 0;
   int checks = 0;

   bit          mem_ready_en;
   int          mem_lat;
   bit          will_acc;
   bit          pend;
   int          pend_cnt;
   logic [31:0] acc_addr;
   logic [31:0] pend_addr;
   logic [31:0] acc_q[$];
   logic [31:0] got_pc_q[$];
   logic [31:0] got_instr_q[$];
   bit          seen_104;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return 32'hA500_0000 | a;
   endfunction

   // Memory model and decode monitor, evaluated on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         pend                   = 1'b0;
         will_acc               = 1'b0;
         bus_if.imem_rsp_valid  = 1'b0;
         bus_if.imem_rsp_data   = 32'h0;
         bus_if.imem_req_ready  = 1'b0;
      end else begin
         bus_if.imem_rsp_valid = 1'b0;
         if (will_acc) begin
            checks++;
            if (pend) begin
               errors++;
               $display("FAIL outstanding: request %h accepted while %h still pending", acc_addr, pend_addr);
            end
            pend      = 1'b1;
            pend_addr = acc_addr;
            pend_cnt  = mem_lat - 1;
            acc_q.push_back(acc_addr);
         end
         if (pend) begin
            if (pend_cnt == 0) begin
               bus_if.imem_rsp_valid = 1'b1;
               bus_if.imem_rsp_data  = word_at(pend_addr);
               pend = 1'b0;
            end else begin
               pend_cnt--;
            end
         end
         bus_if.imem_req_ready = mem_ready_en;
         will_acc = bus_if.imem_req_valid && mem_ready_en;
         acc_addr = bus_if.imem_req_addr;
         if (bus_if.imem_req_valid) begin
            checks++;
            if (bus_if.imem_req_addr[1:0] !== 2'b00) begin
               errors++;
               $display("FAIL req_align: addr %h has low bits set", bus_if.imem_req_addr);
            end
         end
         if (bus_if.if_valid && bus_if.if_ready) begin
            got_pc_q.push_back(bus_if.if_pc);
            got_instr_q.push_back(bus_if.if_instr);
         end
         if (bus_if.if_valid && bus_if.if_pc == 32'h104) seen_104 = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input bit st, input int lat);
      rst            = 1'b1;
      stall          = st;
      redirect_valid = 1'b0;
      redirect_sel   = 2'b00;
      add_extend     = 32'h0;
      jalr_target    = 32'h0;
      bus_if.if_ready = 1'b1;
      mem_ready_en   = 1'b1;
      mem_lat        = lat;
      tick();
      tick();
      acc_q.delete();
      got_pc_q.delete();
      got_instr_q.delete();
      seen_104 = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_sel   = 2'b00;
      add_extend     = 32'h0;
      jalr_target    = 32'h0;
      bus_if.if_ready = 1'b1;
      mem_ready_en   = 1'b1;
      mem_lat        = 1;
      seen_104       = 1'b0;
      tick();
      checks++; if (pc !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, RST_PC); end
      checks++; if (bus_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", bus_if.imem_req_valid); end
      checks++; if (bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b expected 0", bus_if.if_valid); end
      checks++; if (bus_if.if_instr !== NOP) begin errors++; $display("FAIL reset_if_instr: got %h expected %h", bus_if.if_instr, NOP); end
      checks++; if (bus_if.if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc: got %h expected 0", bus_if.if_pc); end
      checks++; if (misalign_exc !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign_exc); end
      tick();
      acc_q.delete();
      got_pc_q.delete();
      got_instr_q.delete();
      rst = 1'b0;
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      for (int i = 0; i < 40 && got_pc_q.size() < 3; i++) tick();
      checks++;
      if (got_pc_q.size() < 3) begin
         errors++;
         $display("FAIL seq_timeout: got %0d instructions expected 3", got_pc_q.size());
         return;
      end
      for (int k = 0; k < 3; k++) begin
         exp_pc = RST_PC + 32'(4 * k);
         checks++; if (acc_q[k] !== exp_pc) begin errors++; $display("FAIL seq_req_addr%0d: got %h expected %h", k, acc_q[k], exp_pc); end
         checks++; if (got_pc_q[k] !== exp_pc) begin errors++; $display("FAIL seq_if_pc%0d: got %h expected %h", k, got_pc_q[k], exp_pc); end
         checks++; if (got_instr_q[k] !== word_at(exp_pc)) begin errors++; $display("FAIL seq_if_instr%0d: got %h expected %h", k, got_instr_q[k], word_at(exp_pc)); end
      end
   endtask

   task automatic test_stall();
      do_reset(1'b1, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (bus_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_idle_req: cycle %0d got %b expected 0", i, bus_if.imem_req_valid); end
         checks++; if (pc !== RST_PC) begin errors++; $display("FAIL stall_idle_pc: cycle %0d got %h expected %h", i, pc, RST_PC); end
      end
      mem_ready_en = 1'b0;
      stall = 1'b0;
      tick();
      checks++; if (bus_if.imem_req_valid !== 1'b1) begin errors++; $display("FAIL stall_enter_req: got %b expected 1", bus_if.imem_req_valid); end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus_if.imem_req_valid !== 1'b1) begin errors++; $display("FAIL stall_req_held: cycle %0d got %b expected 1", i, bus_if.imem_req_valid); end
         checks++; if (bus_if.imem_req_addr !== RST_PC) begin errors++; $display("FAIL stall_req_addr: cycle %0d got %h expected %h", i, bus_if.imem_req_addr, RST_PC); end
      end
      mem_ready_en = 1'b1;
      for (int i = 0; i < 6 && acc_q.size() < 1; i++) tick();
      checks++;
      if (acc_q.size() != 1) begin
         errors++;
         $display("FAIL stall_accept: got %0d accepts expected 1", acc_q.size());
         return;
      end
      checks++; if (acc_q[0] !== RST_PC) begin errors++; $display("FAIL stall_accept_addr: got %h expected %h", acc_q[0], RST_PC); end
      for (int i = 0; i < 3; i++) tick();
      checks++; if (bus_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_after_req: got %b expected 0", bus_if.imem_req_valid); end
      checks++; if (pc !== RST_PC + 32'h4) begin errors++; $display("FAIL stall_after_pc: got %h expected %h", pc, RST_PC + 32'h4); end
   endtask

   task automatic test_backpressure();
      do_reset(1'b0, 1);
      bus_if.if_ready = 1'b0;
      for (int i = 0; i < 10 && bus_if.if_valid !== 1'b1; i++) tick();
      checks++;
      if (bus_if.if_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_fill: got if_valid %b expected 1", bus_if.if_valid);
         return;
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (bus_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_no_req: cycle %0d got %b expected 0", i, bus_if.imem_req_valid); end
         checks++; if (bus_if.if_pc !== RST_PC) begin errors++; $display("FAIL bp_if_pc: cycle %0d got %h expected %h", i, bus_if.if_pc, RST_PC); end
         checks++; if (bus_if.if_instr !== word_at(RST_PC)) begin errors++; $display("FAIL bp_if_instr: cycle %0d got %h expected %h", i, bus_if.if_instr, word_at(RST_PC)); end
      end
      bus_if.if_ready = 1'b1;
      tick();
      checks++; if (bus_if.imem_req_valid !== 1'b1) begin errors++; $display("FAIL bp_release_req: got %b expected 1", bus_if.imem_req_valid); end
      checks++; if (bus_if.imem_req_addr !== RST_PC + 32'h4) begin errors++; $display("FAIL bp_release_addr: got %h expected %h", bus_if.imem_req_addr, RST_PC + 32'h4); end
      checks++; if (bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed: got %b expected 0", bus_if.if_valid); end
   endtask

   task automatic test_branch_redirect();
      do_reset(1'b0, 3);
      for (int i = 0; i < 30 && acc_q.size() < 2; i++) tick();
      checks++;
      if (acc_q.size() != 2) begin
         errors++;
         $display("FAIL br_reach_wait: got %0d accepts expected 2", acc_q.size());
         return;
      end
      checks++; if (acc_q[1] !== 32'h104) begin errors++; $display("FAIL br_wait_addr: got %h expected 00000104", acc_q[1]); end
      redirect_valid = 1'b1;
      redirect_sel   = 2'b01;
      add_extend     = 32'h200;
      tick();
      redirect_valid = 1'b0;
      checks++; if (pc !== 32'h200) begin errors++; $display("FAIL br_pc: got %h expected 00000200", pc); end
      checks++; if (bus_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL br_drop_req: got %b expected 0", bus_if.imem_req_valid); end
      for (int i = 0; i < 30 && got_pc_q.size() < 2; i++) tick();
      checks++;
      if (got_pc_q.size() < 2) begin
         errors++;
         $display("FAIL br_timeout: got %0d instructions expected 2", got_pc_q.size());
         return;
      end
      checks++; if (got_pc_q[0] !== RST_PC) begin errors++; $display("FAIL br_first_pc: got %h expected %h", got_pc_q[0], RST_PC); end
      checks++; if (got_pc_q[1] !== 32'h200) begin errors++; $display("FAIL br_next_pc: got %h expected 00000200", got_pc_q[1]); end
      checks++; if (got_instr_q[1] !== word_at(32'h200)) begin errors++; $display("FAIL br_next_instr: got %h expected %h", got_instr_q[1], word_at(32'h200)); end
      checks++; if (acc_q[2] !== 32'h200) begin errors++; $display("FAIL br_next_req: got %h expected 00000200", acc_q[2]); end
      checks++; if (seen_104 !== 1'b0) begin errors++; $display("FAIL br_no_104: got seen=%b expected 0", seen_104); end
   endtask

   task automatic test_jalr();
      logic [31:0] pc_before;
      do_reset(1'b1, 1);
      tick();
      redirect_valid = 1'b1;
      redirect_sel   = 2'b10;
      jalr_target    = 32'h301;
      tick();
      redirect_valid = 1'b0;
      checks++; if (pc !== 32'h300) begin errors++; $display("FAIL jalr_pc: got %h expected 00000300", pc); end
      stall = 1'b0;
      for (int i = 0; i < 20 && got_pc_q.size() < 1; i++) tick();
      checks++;
      if (got_pc_q.size() < 1) begin
         errors++;
         $display("FAIL jalr_timeout: got %0d instructions expected 1", got_pc_q.size());
         return;
      end
      checks++; if (acc_q[0] !== 32'h300) begin errors++; $display("FAIL jalr_req_addr: got %h expected 00000300", acc_q[0]); end
      checks++; if (got_pc_q[0] !== 32'h300) begin errors++; $display("FAIL jalr_if_pc: got %h expected 00000300", got_pc_q[0]); end
      checks++; if (got_instr_q[0] !== word_at(32'h300)) begin errors++; $display("FAIL jalr_if_instr: got %h expected %h", got_instr_q[0], word_at(32'h300)); end
      pc_before      = pc;
      redirect_valid = 1'b1;
      redirect_sel   = 2'b10;
      jalr_target    = 32'h302;
      tick();
      redirect_valid = 1'b0;
      checks++; if (misalign_exc !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", misalign_exc); end
      checks++; if (pc !== pc_before) begin errors++; $display("FAIL mis_pc_hold: got %h expected %h", pc, pc_before); end
      checks++; if (bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL mis_flush: got %b expected 0", bus_if.if_valid); end
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++; if (bus_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL halt_no_req: cycle %0d got %b expected 0", i, bus_if.imem_req_valid); end
      end
      redirect_valid = 1'b1;
      redirect_sel   = 2'b01;
      add_extend     = 32'h400;
      tick();
      redirect_valid = 1'b0;
      checks++; if (pc !== pc_before) begin errors++; $display("FAIL halt_ignore_redirect: got %h expected %h", pc, pc_before); end
      checks++; if (misalign_exc !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b expected 1", misalign_exc); end
      checks++; if (bus_if.if_instr !== NOP) begin errors++; $display("FAIL halt_nop: got %h expected %h", bus_if.if_instr, NOP); end
   endtask

   task automatic test_rst_mid_wait();
      do_reset(1'b0, 3);
      for (int i = 0; i < 30 && acc_q.size() < 2; i++) tick();
      checks++;
      if (acc_q.size() != 2) begin
         errors++;
         $display("FAIL rw_reach_wait: got %0d accepts expected 2", acc_q.size());
         return;
      end
      #1;
      rst = 1'b1;
      #1;
      checks++; if (pc !== RST_PC) begin errors++; $display("FAIL rw_pc: got %h expected %h", pc, RST_PC); end
      checks++; if (bus_if.if_pc !== 32'h0) begin errors++; $display("FAIL rw_if_pc: got %h expected 0", bus_if.if_pc); end
      checks++; if (bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL rw_if_valid: got %b expected 0", bus_if.if_valid); end
      checks++; if (bus_if.if_instr !== NOP) begin errors++; $display("FAIL rw_if_instr: got %h expected %h", bus_if.if_instr, NOP); end
      checks++; if (bus_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_req_valid: got %b expected 0", bus_if.imem_req_valid); end
      tick();
      acc_q.delete();
      got_pc_q.delete();
      got_instr_q.delete();
      rst = 1'b0;
      for (int i = 0; i < 10 && acc_q.size() < 1; i++) tick();
      checks++;
      if (acc_q.size() < 1) begin
         errors++;
         $display("FAIL rw_restart: got %0d accepts expected 1", acc_q.size());
         return;
      end
      checks++; if (acc_q[0] !== RST_PC) begin errors++; $display("FAIL rw_first_req: got %h expected %h", acc_q[0], RST_PC); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_backpressure();
      test_branch_redirect();
      test_jalr();
      test_rst_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Owns the architectural fetch PC register for the RV32I core.
- Drives `pc` into the external `pc_add4` adder and consumes its `pc_plus4` result for sequential fetch.
- Consumes `add_extend` (from `pc_addimm`) and the JALR target to redirect fetch.
- Issues one-outstanding instruction-memory requests and presents fetched instructions to decode through a single-entry valid/ready output register.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- NOP_INSTR, 32'h00000013, value held in if_instr when no valid instruction is present.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc  output  32  current fetch PC; feeds pc_add4.
- pc_plus4  input  32  pc+4 from pc_add4, combinational on pc.
- add_extend  input  32  branch/JAL target from pc_addimm.
- jalr_target  input  32  rs1+imm from the ALU.
- redirect_valid  input  1  execute requests a redirect this cycle.
- redirect_sel  input  2  01 = add_extend, 10 = jalr_target; 00/11 = ignored.
- stall  input  1  hazard unit blocks issue of new fetches.
- imem_req_valid  output  1  fetch request.
- imem_req_addr  output  32  fetch address.
- imem_req_ready  input  1  memory accepts request.
- imem_rsp_valid  input  1  response data valid.
- imem_rsp_data  input  32  fetched instruction word.
- if_valid  output  1  decode slot holds an instruction.
- if_instr  output  32  instruction to decode.
- if_pc  output  32  PC of if_instr.
- if_ready  input  1  decode consumes the slot.
- misalign_exc  output  1  sticky misaligned-target flag.

Behaviour:
- Reset (async, asserted):
  - pc=RESET_PC, state=IDLE, if_valid=0, if_instr=NOP_INSTR, if_pc=0, misalign_exc=0, imem_req_valid=0, internal req_pc=0.
- States: IDLE, REQ, WAIT, DROP, HALT.
- slot_free = !if_valid || if_ready.
- IDLE:
  - imem_req_valid=0.
  - If !stall && slot_free, go to REQ next cycle.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - Request is held stable until accepted; stall does not deassert it.
  - On imem_req_ready: req_pc<=pc, pc<=pc_plus4, go to WAIT.
- WAIT:
  - On imem_rsp_valid: if_instr<=imem_rsp_data, if_pc<=req_pc, if_valid<=1, go to IDLE.
  - The slot is guaranteed empty because issue required slot_free.
- Slot consumption: if_valid && if_ready clears if_valid and sets if_instr=NOP_INSTR next cycle, unless a response loads it that same cycle.
- Minimum issue cadence with 1-cycle memory: one instruction per 3 cycles. Throughput is not a goal of this block.
- Redirect (redirect_valid && redirect_sel in {01,10}) has priority over stall and sequential update:
  - target = add_extend (sel 01) or {jalr_target[31:1],1'b0} (sel 10).
  - pc<=target; if_valid<=0 (flush decode slot).
  - In REQ without ready: request is withdrawn, go to IDLE.
  - In REQ with ready the same cycle: the accepted request is wrong-path, go to DROP.
  - In WAIT without rsp_valid: go to DROP.
  - In WAIT with rsp_valid the same cycle: discard the response, go to IDLE.
  - In DROP: only pc is updated.
- DROP:
  - imem_req_valid=0.
  - On imem_rsp_valid: discard the data, go to IDLE.
- Misaligned target (target[1]=1):
  - pc unchanged, slot flushed, misalign_exc<=1 (sticky), go to HALT. An in-flight response is ignored.
- HALT: no requests; leaves only on rst.
- Assertions for verification:
  - At most one outstanding request.
  - imem_req_addr[1:0]==0 whenever imem_req_valid.

Test Plan:
- Reset with RESET_PC=0x100, stall=0, if_ready=1, 1-cycle memory: imem_req_addr sequence 0x100, 0x104, 0x108; if_pc matches; if_instr equals returned words in order.
- stall=1 for 5 cycles while in IDLE: no imem_req_valid and pc holds. stall asserted while in REQ: request stays valid until accepted.
- if_ready=0 with slot full: no new request issued; if_instr/if_pc stable. Raise if_ready: next fetch issued within 1 cycle.
- Branch redirect (sel=01, add_extend=0x200) while in WAIT for 0x104: the 0x104 response is dropped, the next if_pc is 0x200, and if_valid is never 1 for 0x104.
- JALR redirect with jalr_target=0x301: fetches 0x300. jalr_target=0x302: misalign_exc=1, HALT, no further imem_req_valid until rst.
- rst asserted mid-WAIT: all outputs return to reset values immediately (async). After release, the first request goes to RESET_PC.
